// File: rtl/tcs3200_emulator.sv
// TCS3200 colour-sensor stand-in: selected filter half-period scaled by S0/S1 drives a 50 % square wave on sensor_out.
// Latency: select pins seen 2 clocks later, OUT held low SETTLE_CYCLES clocks, then toggles every scaled half-period.
// No backpressure; outputs free-run. Define TCS_JITTER_EN to add +/-1 clock LFSR jitter per half-period.
module tcs3200_emulator #(
  parameter int SETTLE_CYCLES = 1000,
  parameter int HP_W          = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s0,
  input  logic            s1,
  input  logic            s2,
  input  logic            s3,
  input  logic [HP_W-1:0] red_hp,
  input  logic [HP_W-1:0] green_hp,
  input  logic [HP_W-1:0] blue_hp,
  input  logic [HP_W-1:0] clear_hp,
  output logic            sensor_out,
  output logic            active,
  output logic [15:0]     edge_cnt
);
  localparam int SW   = HP_W + 6;
  localparam int ST_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      sel_q, sel_d, sel_qq, sel_qq_d;
  logic [ST_W-1:0] settle_q, settle_d;
  logic [SW-1:0]   hp_cnt_q, hp_cnt_d;
  logic            out_q, out_d;
  logic [15:0]     edge_cnt_q, edge_cnt_d;
  logic [HP_W-1:0] hp_sel;
  logic [SW-1:0]   scaled_hp, load_val;
  logic            sel_chg, hp_ok, reload;

  always_comb begin
    sel_d    = {s0, s1, s2, s3};
    sel_qq_d = sel_q;
    sel_chg  = (sel_q != sel_qq);
    case (sel_q[1:0])
      2'b00:   hp_sel = red_hp;
      2'b01:   hp_sel = blue_hp;
      2'b10:   hp_sel = clear_hp;
      default: hp_sel = green_hp;
    endcase
    case (sel_q[3:2])
      2'b11:   scaled_hp = SW'(hp_sel);
      2'b10:   scaled_hp = SW'(hp_sel) * SW'(5);
      2'b01:   scaled_hp = SW'(hp_sel) * SW'(50);
      default: scaled_hp = '0;
    endcase
    hp_ok = (sel_q[3:2] != 2'b00) && (hp_sel != '0);
  end

`ifdef TCS_JITTER_EN
  logic [15:0]   lfsr_q, lfsr_d;
  logic [SW-1:0] base_val;

  // LFSR[1:0]: 00 shortens, 11 lengthens, otherwise exact; never below a 1-clock half-period
  always_comb begin
    base_val = scaled_hp - SW'(1);
    lfsr_d   = lfsr_q;
    case (lfsr_q[1:0])
      2'b00:   load_val = (base_val == '0) ? '0 : base_val - SW'(1);
      2'b11:   load_val = scaled_hp;
      default: load_val = base_val;
    endcase
    if (reload) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) lfsr_q <= 16'hACE1;
    else      lfsr_q <= lfsr_d;
  end
`else
  always_comb load_val = scaled_hp - SW'(1);
`endif

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    hp_cnt_d = hp_cnt_q;
    out_d    = out_q;
    reload   = 1'b0;
    if (sel_chg) begin
      state_d  = ST_SETTLE;
      settle_d = '0;
      out_d    = 1'b0;
    end else if (state_q != ST_OFF && !hp_ok) begin
      state_d  = ST_OFF;
      settle_d = '0;
      hp_cnt_d = '0;
      out_d    = 1'b0;
    end else begin
      case (state_q)
        ST_OFF: begin
          settle_d = '0;
          hp_cnt_d = '0;
          out_d    = 1'b0;
          if (hp_ok) state_d = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_q == ST_W'(SETTLE_CYCLES - 1)) begin
            state_d  = ST_RUN;
            out_d    = 1'b1;
            hp_cnt_d = load_val;
            reload   = 1'b1;
          end else begin
            settle_d = settle_q + ST_W'(1);
          end
        end
        ST_RUN: begin
          if (hp_cnt_q == '0) begin
            out_d    = ~out_q;
            hp_cnt_d = load_val;
            reload   = 1'b1;
          end else begin
            hp_cnt_d = hp_cnt_q - SW'(1);
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
    edge_cnt_d = edge_cnt_q;
    if (sel_chg)             edge_cnt_d = '0;
    else if (out_d && !out_q) edge_cnt_d = edge_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_OFF;
      sel_q      <= '0;
      sel_qq     <= '0;
      settle_q   <= '0;
      hp_cnt_q   <= '0;
      out_q      <= 1'b0;
      edge_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      sel_qq     <= sel_qq_d;
      settle_q   <= settle_d;
      hp_cnt_q   <= hp_cnt_d;
      out_q      <= out_d;
      edge_cnt_q <= edge_cnt_d;
    end
  end

  assign sensor_out = out_q;
  assign active     = (state_q == ST_RUN);
  assign edge_cnt   = edge_cnt_q;
endmodule
